pgs_tsmac_gmii_rx_frame_parser_v1_0: RTL and testbench

//  Consumes the GMII receive stream (rxd_gm/rx_dv_gm/rx_er_gm) from the RGMII->GMII converter.

---
 rtl/pgs_tsmac_gmii_rx_frame_parser_v1_0.sv | 196 +++++++++++++++++++
 tb/tb_pgs_tsmac_gmii_rx_frame_parser_v1_0.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pgs_tsmac_gmii_rx_frame_parser_v1_0.sv
//------------------------------------------------------------------------------
// pgs_tsmac_gmii_rx_frame_parser_v1_0
// GMII RX parser: strips preamble/SFD and FCS, checks CRC-32/length/rx_er.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pgs_tsmac_gmii_rx_frame_parser_v1_0 #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        rx_dv_gm,
  input  logic        rx_er_gm,
  input  logic [7:0]  rxd_gm,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic        out_bad,
  output logic [13:0] frame_len,
  output logic        stat_ok,
  output logic        stat_crc_err,
  output logic        stat_len_err,
  output logic        stat_gmii_err
);

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [13:0] LEN_SAT     = 14'h3FFF;
  localparam logic [13:0] LEN_MIN     = 14'(MIN_FRAME);
  localparam logic [13:0] LEN_MAX     = 14'(MAX_FRAME);
  localparam logic [13:0] DL_DEPTH    = 14'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t          state, state_nxt;
  logic [31:0]     crc, crc_nxt;
  logic [13:0]     len, len_nxt;
  logic            gmii_err, gmii_err_nxt;
  // dl[0] is the oldest byte once the line has been filled
  logic [4:0][7:0] dl, dl_nxt;

  logic            valid_nxt, sof_nxt, eof_nxt, good_nxt, bad_nxt;
  logic [7:0]      data_nxt;
  logic [13:0]     flen_nxt;
  logic            ok_nxt, crc_err_nxt, len_err_nxt, gmii_err_pulse_nxt;
  logic            crc_bad, len_bad, frame_good;

  assign crc_bad    = (crc != CRC_RESIDUE);
  assign len_bad    = (len < LEN_MIN) || (len > LEN_MAX);
  assign frame_good = !(crc_bad || len_bad || gmii_err);

  always_comb begin
    state_nxt          = state;
    crc_nxt            = crc;
    len_nxt            = len;
    gmii_err_nxt       = gmii_err;
    dl_nxt             = dl;
    valid_nxt          = 1'b0;
    data_nxt           = 8'h00;
    sof_nxt            = 1'b0;
    eof_nxt            = 1'b0;
    good_nxt           = 1'b0;
    bad_nxt            = 1'b0;
    flen_nxt           = 14'd0;
    ok_nxt             = 1'b0;
    crc_err_nxt        = 1'b0;
    len_err_nxt        = 1'b0;
    gmii_err_pulse_nxt = 1'b0;

    case (state)
      S_IDLE, S_PREAMBLE: begin
        if (!rx_dv_gm) begin
          state_nxt = S_IDLE;
        end else if (rxd_gm == PRE_BYTE) begin
          state_nxt = S_PREAMBLE;
        end else if (rxd_gm == SFD_BYTE) begin
          state_nxt    = S_DATA;
          crc_nxt      = CRC_INIT;
          len_nxt      = 14'd0;
          gmii_err_nxt = 1'b0;
        end else begin
          state_nxt = S_DROP;
        end
      end

      S_DATA: begin
        if (rx_dv_gm) begin
          crc_nxt = crc_byte(crc, rxd_gm);
          len_nxt = (len == LEN_SAT) ? len : len + 14'd1;
          dl_nxt  = {rxd_gm, dl[4:1]};
          if (rx_er_gm) gmii_err_nxt = 1'b1;
          if (len >= DL_DEPTH) begin
            valid_nxt = 1'b1;
            data_nxt  = dl[0];
            sof_nxt   = (len == DL_DEPTH);
          end
        end else begin
          // First idle cycle closes the frame; the 4 FCS bytes left in the line are dropped
          state_nxt = S_IDLE;
          if (len >= DL_DEPTH) begin
            valid_nxt          = 1'b1;
            data_nxt           = dl[0];
            sof_nxt            = (len == DL_DEPTH);
            eof_nxt            = 1'b1;
            good_nxt           = frame_good;
            bad_nxt            = !frame_good;
            flen_nxt           = len;
            ok_nxt             = frame_good;
            crc_err_nxt        = crc_bad;
            len_err_nxt        = len_bad;
            gmii_err_pulse_nxt = gmii_err;
          end else begin
            len_err_nxt = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (!rx_dv_gm) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      crc           <= CRC_INIT;
      len           <= 14'd0;
      gmii_err      <= 1'b0;
      dl            <= '0;
      out_valid     <= 1'b0;
      out_data      <= 8'h00;
      out_sof       <= 1'b0;
      out_eof       <= 1'b0;
      out_good      <= 1'b0;
      out_bad       <= 1'b0;
      frame_len     <= 14'd0;
      stat_ok       <= 1'b0;
      stat_crc_err  <= 1'b0;
      stat_len_err  <= 1'b0;
      stat_gmii_err <= 1'b0;
    end else begin
      crc           <= crc_nxt;
      len           <= len_nxt;
      gmii_err      <= gmii_err_nxt;
      dl            <= dl_nxt;
      out_valid     <= valid_nxt;
      out_data      <= data_nxt;
      out_sof       <= sof_nxt;
      out_eof       <= eof_nxt;
      out_good      <= good_nxt;
      out_bad       <= bad_nxt;
      frame_len     <= flen_nxt;
      stat_ok       <= ok_nxt;
      stat_crc_err  <= crc_err_nxt;
      stat_len_err  <= len_err_nxt;
      stat_gmii_err <= gmii_err_pulse_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pgs_tsmac_gmii_rx_frame_parser_v1_0.sv
//------------------------------------------------------------------------------
// tb_pgs_tsmac_gmii_rx_frame_parser_v1_0
// Scoreboard bench: stimulus pushes expected beats, a monitor pops and compares.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pgs_tsmac_gmii_rx_frame_parser_v1_0;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b0;
  logic        rx_dv_gm = 1'b0;
  logic        rx_er_gm = 1'b0;
  logic [7:0]  rxd_gm = 8'h00;
  logic        out_valid, out_sof, out_eof, out_good, out_bad;
  logic [7:0]  out_data;
  logic [13:0] frame_len;
  logic        stat_ok, stat_crc_err, stat_len_err, stat_gmii_err;

  pgs_tsmac_gmii_rx_frame_parser_v1_0 #(.MIN_FRAME(64), .MAX_FRAME(1522)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_dv_gm(rx_dv_gm), .rx_er_gm(rx_er_gm),
    .rxd_gm(rxd_gm), .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
    .out_eof(out_eof), .out_good(out_good), .out_bad(out_bad), .frame_len(frame_len),
    .stat_ok(stat_ok), .stat_crc_err(stat_crc_err), .stat_len_err(stat_len_err),
    .stat_gmii_err(stat_gmii_err)
  );

  always #4 rx_clk = ~rx_clk;

  typedef struct packed {
    logic        valid;
    logic [7:0]  data;
    logic        sof, eof, good, bad;
    logic [13:0] flen;
    logic        ok, crc, len, gmii;
  } exp_t;

  exp_t exp_q[$];
  exp_t act;
  int   n_checks = 0;
  int   n_fail   = 0;

  assign act = {out_valid, out_data, out_sof, out_eof, out_good, out_bad, frame_len,
                stat_ok, stat_crc_err, stat_len_err, stat_gmii_err};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every cycle with a data beat or a stat pulse consumes one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge rx_clk);
      if (rx_rst && (out_valid || stat_ok || stat_crc_err || stat_len_err || stat_gmii_err)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected nothing", act);
        end else begin
          e = exp_q.pop_front();
          check("beat", act, e);
        end
      end
    end
  end

  function automatic logic [31:0] crc32_update(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge rx_clk);
    #1;
    rx_dv_gm = dv;
    rxd_gm   = d;
    rx_er_gm = er;
  endtask

  task automatic preamble();
    repeat (7) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
  endtask

  // Payload byte i = i mod 256, valid FCS appended; optional bit flip, rx_er, reset hit
  task automatic send_frame(input int plen, input int flip_idx, input int er_idx,
                            input int rst_idx);
    logic [7:0]  b[$];
    logic [31:0] c;
    exp_t        e;
    int          len;
    logic        good;
    b = {};
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      b.push_back(8'(i));
      c = crc32_update(c, 8'(i));
    end
    c = ~c;
    for (int j = 0; j < 4; j++) b.push_back(c[8*j +: 8]);
    if (flip_idx >= 0) b[flip_idx] = b[flip_idx] ^ 8'h01;
    len  = plen + 4;
    good = (flip_idx < 0) && (er_idx < 0) && (len >= 64) && (len <= 1522);
    for (int k = 0; k < plen; k++) begin
      if (rst_idx < 0 || k < rst_idx - 6) begin
        e       = '0;
        e.valid = 1'b1;
        e.data  = b[k];
        e.sof   = (k == 0);
        if (k == plen - 1 && rst_idx < 0) begin
          e.eof  = 1'b1;
          e.good = good;
          e.bad  = !good;
          e.flen = 14'(len);
          e.ok   = good;
          e.crc  = (flip_idx >= 0);
          e.len  = (len < 64) || (len > 1522);
          e.gmii = (er_idx >= 0);
        end
        exp_q.push_back(e);
      end
    end
    preamble();
    for (int i = 0; i < len; i++) begin
      drive(1'b1, b[i], i == er_idx);
      if (i == rst_idx) rx_rst = 1'b0;
      if (rst_idx >= 0 && i == rst_idx + 1) check("in_reset_outputs", act, 32'h0);
      if (rst_idx >= 0 && i == rst_idx + 3) rx_rst = 1'b1;
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge rx_clk);
      t++;
    end
    repeat (2) @(negedge rx_clk);
    check(name, 32'(exp_q.size()), 32'h0);
    exp_q = {};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge rx_clk);
    check("reset_outputs", act, 32'h0);
    @(posedge rx_clk);
    #1 rx_rst = 1'b1;
    repeat (2) @(posedge rx_clk);

    send_frame(60, -1, -1, -1);           drain("drain_good64");
    send_frame(60, 10, -1, -1);           drain("drain_crc_err");
    send_frame(60, -1, 20, -1);           drain("drain_gmii_err");
    send_frame(56, -1, -1, -1);           drain("drain_len60");
    send_frame(1519, -1, -1, -1);         drain("drain_len1523");
    send_frame(1518, -1, -1, -1);         drain("drain_len1522");
    send_frame(1, -1, -1, -1);            drain("drain_len5");

    // len 3: no data beats, only a length-error pulse
    e     = '0;
    e.len = 1'b1;
    exp_q.push_back(e);
    preamble();
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drain("drain_len3");

    // Broken preamble is dropped, then a good frame after a 1-cycle gap
    repeat (7) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h5D, 1'b0);
    repeat (8) drive(1'b1, 8'hAA, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    send_frame(60, -1, -1, -1);           drain("drain_after_drop");

    send_frame(60, -1, -1, 30);           drain("drain_reset_hit");
    send_frame(60, -1, -1, -1);           drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
